mc_ctrl_unit: RTL and testbench

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

---
 rtl/mc_ctrl_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32I control unit: FSM sequencing fetch/decode/execute/memory/writeback.
// Optional macro MC_CTRL_BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu on top of beq.
module mc_ctrl_unit #(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  mem_write,
    output logic                  mem_req,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_srca,
    output logic [1:0]            alu_srcb,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_cntrl,
    output logic                  illegal,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6,  EXECI   = 4'd7,
        ALUWB    = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR    = 4'd11,
        LUI      = 4'd12, TRAP   = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_op_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    state_t     cur;
    state_t     decode_target;
    alu_op_t    exec_op;
    alu_op_t    alu_op;
    logic       branch_ok;
    logic       branch_taken;
    logic       unused_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign state     = cur;

`ifdef MC_CTRL_BRANCH_EXT_EN
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        branch_ok    = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_ok    = 1'b0;
        endcase
    end
`else
    assign unused_bits  = ^{instr[31], instr[29:15], instr[11:7], lt, ltu};
    assign branch_ok    = (funct3 == 3'b000);
    assign branch_taken = zero;
`endif

    always_comb begin
        case (funct3)
            3'b000:  exec_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  exec_op = ALU_SLL;
            3'b010:  exec_op = ALU_SLT;
            3'b011:  exec_op = ALU_SLTU;
            3'b100:  exec_op = ALU_XOR;
            3'b101:  exec_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  exec_op = ALU_OR;
            default: exec_op = ALU_AND;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE: decode_target = MEMADR;
            OP_R:              decode_target = EXECR;
            OP_I:              decode_target = EXECI;
            OP_BR:             decode_target = branch_ok ? BRANCH : TRAP;
            OP_JAL:            decode_target = JAL;
            OP_JALR:           decode_target = JALR;
            OP_LUI:            decode_target = LUI;
            default:           decode_target = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE:   cur <= decode_target;
                MEMADR:   cur <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) cur <= MEMWB;
                MEMWRITE: if (mem_ready) cur <= FETCH;
                EXECR, EXECI, LUI: cur <= ALUWB;
                TRAP:     cur <= TRAP;
                default:  cur <= FETCH;   // writebacks, branch/jumps and unused codes 14-15
            endcase
        end
    end

    always_comb begin
        // NOTE: every output is defaulted first so no state leaves one unassigned and infers a latch.
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_srca   = 2'b00;
        alu_srcb   = 2'b00;
        imm_src    = 3'b000;
        illegal    = 1'b0;
        alu_op     = ALU_ADD;
        case (cur)
            FETCH: begin
                mem_req  = 1'b1;
                alu_srcb = 2'b10;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                alu_srca = 2'b01;
                alu_srcb = 2'b01;
                imm_src  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            MEMADR: begin
                alu_srca = 2'b10;
                alu_srcb = 2'b01;
                imm_src  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_srca = 2'b10;
                alu_op   = exec_op;
            end
            EXECI: begin
                alu_srca = 2'b10;
                alu_srcb = 2'b01;
                alu_op   = exec_op;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                alu_srca = 2'b10;
                alu_op   = ALU_SUB;
                pc_write = branch_taken;
            end
            JAL: begin
                alu_srca  = 2'b01;
                alu_srcb  = 2'b10;
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            JALR: begin
                alu_srca   = 2'b10;
                alu_srcb   = 2'b01;
                result_src = 2'b10;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
            end
            LUI: begin
                alu_srca = 2'b11;   // zero operand, so result is the U immediate
                alu_srcb = 2'b01;
                imm_src  = 3'b100;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        // Reset suppresses side effects immediately, even mid-access, before the state register clears.
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
        alu_cntrl = ALU_CTRL_W'(alu_op);
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Randomized self-checking bench for mc_ctrl_unit: per-instruction expected cycle plan built from
// the instruction semantics, compared against every DUT output each cycle, plus literal anchors.
module tb_mc_ctrl_unit;

    localparam int AW = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef struct packed {
        logic [3:0]    st;
        logic          pcw, memw, memreq, adr, irw, regw;
        logic [1:0]    res, sa, sb;
        logic [2:0]    imm;
        logic [AW-1:0] alu;
        logic          ill;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          zero, lt, ltu, mem_ready;
    logic          pc_write, mem_write, mem_req, adr_src, ir_write, reg_write;
    logic [1:0]    result_src, alu_srca, alu_srcb;
    logic [2:0]    imm_src;
    logic [AW-1:0] alu_cntrl;
    logic          illegal;
    logic [3:0]    state;

    int   tests = 0;
    int   fails = 0;
    obs_t trace[$];

    mc_ctrl_unit #(.ALU_CTRL_W(AW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .pc_write(pc_write), .mem_write(mem_write), .mem_req(mem_req),
        .adr_src(adr_src), .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .imm_src(imm_src), .alu_cntrl(alu_cntrl),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t blank(input int st);
        obs_t o = '0;
        o.st  = 4'(st);
        o.ill = (st == 13);
        return o;
    endfunction

    // ALU operation required by the RV32I mnemonic selected by funct3/funct7[5]
    function automatic logic [AW-1:0] alu_exp(input bit is_r, input logic [2:0] f3, input bit b5);
        case (f3)
            3'd0:    return (is_r && b5) ? AW'(1) : AW'(0);
            3'd1:    return AW'(7);
            3'd2:    return AW'(5);
            3'd3:    return AW'(6);
            3'd4:    return AW'(4);
            3'd5:    return b5 ? AW'(9) : AW'(8);
            3'd6:    return AW'(3);
            default: return AW'(2);
        endcase
    endfunction

    function automatic bit br_ok(input logic [2:0] f3);
`ifdef MC_CTRL_BRANCH_EXT_EN
        return f3 != 3'd2 && f3 != 3'd3;
`else
        return f3 == 3'd0;
`endif
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input bit z, input bit l, input bit u);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return u;
            3'd7:    return !u;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of the plan: drive mem_ready on the falling edge, compare all outputs just after.
    task automatic step(input obs_t e, input logic rdy);
        obs_t a;
        @(negedge clk);
        mem_ready = rdy;
        #1;
        a = {state, pc_write, mem_write, mem_req, adr_src, ir_write, reg_write,
             result_src, alu_srca, alu_srcb, imm_src, alu_cntrl, illegal};
        trace.push_back(a);
        check($sformatf("outputs state%0d", e.st), 32'(a), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("strobes low under reset", 32'({pc_write, mem_write, mem_req, ir_write, reg_write}), 32'd0);
        @(negedge clk);
        #1;
        check("state after reset", 32'(state), 32'd0);
        check("illegal after reset", 32'(illegal), 32'd0);
        reset = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, output bit trapped);
        obs_t       o;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        instr = ins;
        trapped = 1'b0;
        repeat (fw) begin
            o = blank(0); o.memreq = 1'b1; o.sb = 2'd2;
            step(o, 1'b0);
        end
        o = blank(0); o.memreq = 1'b1; o.sb = 2'd2; o.irw = 1'b1; o.pcw = 1'b1;
        step(o, 1'b1);
        o = blank(1); o.sa = 2'd1; o.sb = 2'd1; o.imm = (op == OP_JAL) ? 3'd3 : 3'd2;
        step(o, rnd_bit());
        case (op)
            OP_LOAD, OP_STORE: begin
                o = blank(2); o.sa = 2'd2; o.sb = 2'd1; o.imm = (op == OP_STORE) ? 3'd1 : 3'd0;
                step(o, rnd_bit());
                for (int i = 0; i <= mw; i++) begin
                    o = blank(op == OP_LOAD ? 3 : 5);
                    o.memreq = 1'b1; o.adr = 1'b1; o.memw = (op == OP_STORE);
                    step(o, i == mw);
                end
                if (op == OP_LOAD) begin
                    o = blank(4); o.res = 2'd1; o.regw = 1'b1;
                    step(o, rnd_bit());
                end
            end
            OP_R, OP_I: begin
                o = blank(op == OP_R ? 6 : 7); o.sa = 2'd2; o.sb = (op == OP_R) ? 2'd0 : 2'd1;
                o.alu = alu_exp(op == OP_R, f3, ins[30]);
                step(o, rnd_bit());
                o = blank(8); o.regw = 1'b1;
                step(o, rnd_bit());
            end
            OP_BR: begin
                if (br_ok(f3)) begin
                    o = blank(9); o.sa = 2'd2; o.alu = AW'(1); o.pcw = br_taken(f3, zero, lt, ltu);
                    step(o, rnd_bit());
                end else begin
                    trapped = 1'b1;
                end
            end
            OP_JAL: begin
                o = blank(10); o.sa = 2'd1; o.sb = 2'd2; o.regw = 1'b1; o.pcw = 1'b1;
                step(o, rnd_bit());
            end
            OP_JALR: begin
                o = blank(11); o.sa = 2'd2; o.sb = 2'd1; o.res = 2'd2; o.regw = 1'b1; o.pcw = 1'b1;
                step(o, rnd_bit());
            end
            OP_LUI: begin
                o = blank(12); o.imm = 3'd4; o.sb = 2'd1; o.sa = 2'd3;
                step(o, rnd_bit());
                o = blank(8); o.regw = 1'b1;
                step(o, rnd_bit());
            end
            default: trapped = 1'b1;
        endcase
        if (trapped) repeat (3) step(blank(13), rnd_bit());
    endtask

    initial begin
        bit          tr;
        int          n;
        logic [31:0] ins;
        logic [6:0]  bad_ops [5];
        obs_t        o;
        bad_ops = '{7'h00, 7'h0F, 7'h73, 7'h17, 7'h7F};
        reset = 1'b1; instr = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        do_reset();

        // add x3,x1,x2 with memory always ready
        trace.delete();
        run_instr(32'h002081B3, 0, 0, tr);
        check("add state seq", 32'({trace[0].st, trace[1].st, trace[2].st, trace[3].st}), 32'h0168);
        check("add alu_cntrl in EXECR", 32'(trace[2].alu), 32'd0);
        check("add reg_write only in ALUWB",
              32'({trace[0].regw, trace[1].regw, trace[2].regw, trace[3].regw}), 32'b0001);

        // lw x5,0(x1) with three wait cycles in MEMREAD
        trace.delete();
        run_instr(32'h0000A283, 0, 3, tr);
        n = 0;
        foreach (trace[i]) if (trace[i].st == 4'd3 && trace[i].memreq) n++;
        check("lw MEMREAD cycles with mem_req", 32'(n), 32'd4);
        check("lw MEMWB last", 32'({trace[7].st, trace[7].regw}), 32'h9);

        // sw x2,0(x1) with two wait cycles
        trace.delete();
        run_instr(32'h0020A023, 0, 2, tr);
        n = 0;
        foreach (trace[i]) n += int'(trace[i].memw);
        check("sw mem_write cycles", 32'(n), 32'd3);
        trace.delete();
        run_instr(32'h002081B3, 0, 0, tr);
        check("fetch after sw", 32'(trace[0].st), 32'd0);

        // blt x1,x2 with lt=1
        lt = 1'b1; zero = 1'b0;
        trace.delete();
        run_instr(32'h0020C463, 0, 0, tr);
`ifdef MC_CTRL_BRANCH_EXT_EN
        check("blt taken pc_write", 32'({trace[2].st, trace[2].pcw}), 32'h13);
`else
        check("blt traps", 32'({trace[2].st, trace[2].ill}), 32'h1B);
`endif
        if (tr) do_reset();
        lt = 1'b0;

        // opcode 0000000 traps and stays until reset
        trace.delete();
        run_instr(32'h00000000, 1, 0, tr);
        check("illegal held", 32'({trace[$].st, trace[$].ill}), 32'h1B);
        do_reset();

        // reset in the middle of a stalled store
        instr = 32'h0020A023;
        o = blank(0); o.memreq = 1'b1; o.sb = 2'd2; o.irw = 1'b1; o.pcw = 1'b1;
        step(o, 1'b1);
        o = blank(1); o.sa = 2'd1; o.sb = 2'd1; o.imm = 3'd2;
        step(o, 1'b0);
        o = blank(2); o.sa = 2'd2; o.sb = 2'd1; o.imm = 3'd1;
        step(o, 1'b0);
        o = blank(5); o.memreq = 1'b1; o.adr = 1'b1; o.memw = 1'b1;
        step(o, 1'b0);
        do_reset();

        // randomized instruction stream
        for (int k = 0; k < 160; k++) begin
            ins = $urandom;
            zero = rnd_bit(); lt = rnd_bit(); ltu = rnd_bit();
            case ($urandom_range(0, 9))
                0:       ins[6:0] = OP_LOAD;
                1:       ins[6:0] = OP_STORE;
                2, 9:    ins[6:0] = OP_R;
                3:       ins[6:0] = OP_I;
                4:       ins[6:0] = OP_BR;
                5:       ins[6:0] = OP_JAL;
                6:       ins[6:0] = OP_JALR;
                7:       ins[6:0] = OP_LUI;
                default: ins[6:0] = bad_ops[$urandom_range(0, 4)];
            endcase
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), tr);
            if (tr) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
